// File: rtl/pattern_detector.sv
// pattern_detector
//   Serial bit-pattern detector with a programmable pattern and don't-care
//   mask. Accepted bits (x_valid=1) shift into a PAT_W-bit history. Once
//   PAT_W bits have been taken since the last load (or since the last
//   non-overlapping match), every accepted bit forms a full window that is
//   compared against the pattern under the mask. A registered match flag
//   pulses for one cycle per hit, and a saturating counter tallies hits.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   x          : serial data bit
//   x_valid    : x is accepted only when high
//   pat_load   : strobe, captures pat_in/pat_mask and restarts filling
//   pat_in     : pattern, MSB = oldest bit, LSB = newest bit
//   pat_mask   : 1 = compare bit, 0 = don't-care
//   overlap    : 1 = overlapping detection, 0 = restart after each match
//   clr_cnt    : synchronous clear of match_cnt (wins over increment)
//   match      : registered one-cycle match flag
//   match_cnt  : saturating match count
//   state_o    : IDLE=0, FILL=1, ARMED=2
module pattern_detector #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [PAT_W-1:0] pat_mask,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state_o
);

  localparam int unsigned FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   mask_q, mask_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_W-1:0]   window;
  logic               hit;
  logic               full;

  // Candidate window is the history as it will look after this bit shifts in.
  assign window = (hist_q << 1) | PAT_W'(x);
  assign hit    = ((window ~^ pat_q) & mask_q) == mask_q;

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    match_d = 1'b0;
    full    = 1'b0;

    if (pat_load) begin
      // A load restarts detection; a bit offered in the same cycle is dropped.
      pat_d   = pat_in;
      mask_d  = pat_mask;
      hist_d  = '0;
      fill_d  = '0;
      state_d = FILL;
    end else begin
      case (state_q)
        IDLE: ;
        FILL, ARMED: begin
          if (x_valid) begin
            hist_d = window;
            if (state_q == ARMED) begin
              full = 1'b1;
            end else begin
              fill_d = fill_q + FW'(1);
              full   = (fill_q >= FILL_LAST);
            end
            if (full) begin
              state_d = ARMED;
              if (hit) begin
                match_d = 1'b1;
                if (!overlap) begin
                  // History is kept, but PAT_W fresh bits are needed again.
                  fill_d  = '0;
                  state_d = FILL;
                end
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (match_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      mask_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign state_o   = state_q;

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 8: match counter width, legal range 1..16.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: asynchronous active-low reset (one clock; reset is asynchronous and active-low).
REQ-005 Port x, input, 1: serial data bit.
REQ-006 Port x_valid, input, 1: x is sampled only in cycles where x_valid=1.
REQ-007 Port pat_load, input, 1: single-cycle strobe that loads pat_in and pat_mask.
REQ-008 Port pat_in, input, PAT_W: pattern; bit PAT_W-1 is matched against the oldest bit, bit 0 against the newest.
REQ-009 Port pat_mask, input, PAT_W: 1 = compare this bit, 0 = don't-care.
REQ-010 Port overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping; sampled each cycle.
REQ-011 Port clr_cnt, input, 1: synchronous clear of match_cnt.
REQ-012 Port match, output, 1: registered (Moore) match flag.
REQ-013 Port match_cnt, output, CNT_W: saturating count of matches.
REQ-014 Port state_o, output, 2: current state encoding, IDLE=0, FILL=1, ARMED=2.

Function
REQ-015 Internal registers SHALL be: hist (PAT_W-bit shift register), fill (fill count, 0..PAT_W), pattern register, mask register, and state.
REQ-016 IDLE SHALL be the state until the first pat_load; x_valid is ignored in IDLE.
REQ-017 pat_load SHALL, in any state, capture the pattern and mask, clear hist and fill to 0, and move to FILL on the next edge.
REQ-018 When pat_load and x_valid are high in the same cycle, pat_load SHALL win and that x bit SHALL be discarded.
REQ-019 In FILL or ARMED with x_valid=1, hist SHALL update to {hist[PAT_W-2:0], x}.
REQ-020 In FILL with x_valid=1, fill SHALL increment, saturating at PAT_W.
REQ-021 The state SHALL move FILL->ARMED on the edge where fill reaches PAT_W.
REQ-022 The candidate window SHALL be the shifted value {hist[PAT_W-2:0], x}, taken in the cycle x is accepted, when that bit makes fill equal PAT_W or the state is already ARMED.
REQ-023 The window SHALL match when ((window XNOR pattern) AND mask) equals mask; an all-zero mask matches every full window.
REQ-024 match SHALL assert on the edge that accepts the completing bit, for exactly one cycle.
REQ-025 match SHALL be 0 in any cycle that does not follow a matching accepted bit, including cycles with x_valid=0.
REQ-026 On a match with overlap=1, the state SHALL remain ARMED and hist SHALL be kept.
REQ-027 On a match with overlap=0, fill SHALL be cleared to 0 and the state SHALL return to FILL, so the next match needs PAT_W new bits.
REQ-028 match_cnt SHALL increment on the same edge that match asserts, saturating at 2^CNT_W-1 with no wrap.
REQ-029 clr_cnt SHALL set match_cnt to 0 and SHALL win over a simultaneous increment; match itself is unaffected.
REQ-030 Gaps in x_valid SHALL not affect hist, fill or state.
REQ-031 Unused state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-032 While rst=0, the block SHALL immediately force state=IDLE, match=0, match_cnt=0, hist=0, fill=0, pattern=0 and mask=0, independent of clk.
REQ-033 rst asserted mid-stream SHALL discard the partial history; after release, a new pat_load is required before any detection.
REQ-034 Reset release SHALL take effect on the first rising clk edge after rst goes high.

Verification
REQ-035 Reset then x_valid pulses without pat_load -> state_o=0, match never 1, match_cnt=0.
REQ-036 PAT_W=4, load pattern 1011 with mask 1111, overlap=1, stream 1,0,1,1,0,1,1 -> match after bits 4 and 7, match_cnt=2, state_o=2.
REQ-037 Same load with overlap=0 and the same stream -> match after bit 4 only, match_cnt=1, state_o=1 after the match.
REQ-038 Mask 1001, pattern 1001, stream 1,1,0,1 -> match after bit 4; x_valid held low for 3 cycles between bits gives the same result.
REQ-039 CNT_W=2 with 5 matches -> match_cnt saturates at 3; clr_cnt asserted in the same cycle as a match -> match_cnt=0 and match=1.
REQ-040 Reset asserted after 2 of 4 bits, then released, then load and a 4-bit matching stream -> a single match only after all 4 new bits; pat_load with x_valid in the same cycle drops that bit (fill=0).
